// File: rtl/vdp_cpu_port.sv
// CPU-side I/O port of the VDP: two-byte control writes, register strobes,
// auto-incrementing VRAM address with a one-byte read prefetch.
module vdp_cpu_port (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  bus_address,
  input  logic        bus_ioreq,
  input  logic        bus_write,
  input  logic        bus_valid,
  input  logic [7:0]  bus_wdata,
  output logic [7:0]  bus_rdata,
  output logic        bus_rdata_en,
  output logic        bus_ready,
  output logic        reg_write,
  output logic [5:0]  reg_num,
  output logic [7:0]  reg_wdata,
  input  logic [7:0]  status_in,
  output logic [16:0] vram_address,
  output logic        vram_write,
  output logic        vram_valid,
  input  logic        vram_ready,
  output logic [7:0]  vram_wdata,
  input  logic [31:0] vram_rdata,
  input  logic        vram_rdata_en
);

  typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ, RD_WAIT} state_t;

  state_t      state, state_nxt;
  logic        first_byte;
  logic [7:0]  latch;
  logic [16:0] addr;
  logic [2:0]  r14;
  logic [7:0]  prefetch;
  logic        accept;

  function automatic logic [7:0] sel_byte(input logic [31:0] word, input logic [1:0] sel);
    case (sel)
      2'd0:    sel_byte = word[7:0];
      2'd1:    sel_byte = word[15:8];
      2'd2:    sel_byte = word[23:16];
      default: sel_byte = word[31:24];
    endcase
  endfunction

  assign bus_ready    = (state == IDLE);
  assign accept       = bus_valid & bus_ioreq & bus_ready;
  assign vram_valid   = (state == WR_REQ) || (state == RD_REQ);
  assign vram_write   = (state == WR_REQ);
  assign vram_address = addr;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bus_address == 2'd0)
            state_nxt = bus_write ? WR_REQ : RD_REQ;
          // second control byte with bits 7:6 = 00 sets up a read address
          else if (bus_address == 2'd1 && bus_write && first_byte &&
                   !bus_wdata[7] && !bus_wdata[6])
            state_nxt = RD_REQ;
        end
      end
      WR_REQ:  if (vram_ready) state_nxt = IDLE;
      RD_REQ:  if (vram_ready) state_nxt = RD_WAIT;
      RD_WAIT: if (vram_rdata_en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first_byte   <= 1'b0;
      latch        <= 8'h00;
      addr         <= 17'h00000;
      r14          <= 3'd0;
      prefetch     <= 8'h00;
      bus_rdata    <= 8'h00;
      bus_rdata_en <= 1'b0;
      reg_write    <= 1'b0;
      reg_num      <= 6'd0;
      reg_wdata    <= 8'h00;
      vram_wdata   <= 8'h00;
    end else begin
      bus_rdata_en <= 1'b0;
      reg_write    <= 1'b0;
      if (accept) begin
        case (bus_address)
          2'd0: begin
            first_byte <= 1'b0;
            if (bus_write) begin
              vram_wdata <= bus_wdata;
            end else begin
              bus_rdata    <= prefetch;
              bus_rdata_en <= 1'b1;
            end
          end
          2'd1: begin
            if (!bus_write) begin
              bus_rdata    <= status_in;
              bus_rdata_en <= 1'b1;
              first_byte   <= 1'b0;
            end else if (!first_byte) begin
              latch      <= bus_wdata;
              first_byte <= 1'b1;
            end else begin
              first_byte <= 1'b0;
              if (bus_wdata[7]) begin
                reg_write <= 1'b1;
                reg_num   <= bus_wdata[5:0];
                reg_wdata <= latch;
                if (bus_wdata[5:0] == 6'd14) r14 <= latch[2:0];
              end else begin
                addr <= {r14, bus_wdata[5:0], latch};
              end
            end
          end
          default: begin
            if (!bus_write) begin
              bus_rdata    <= 8'hFF;
              bus_rdata_en <= 1'b1;
            end
          end
        endcase
      end
      // address increments on write completion or read data return; wraps at 17 bits
      if (state == WR_REQ && vram_ready)
        addr <= addr + 17'd1;
      if (state == RD_WAIT && vram_rdata_en) begin
        prefetch <= sel_byte(vram_rdata, addr[1:0]);
        addr     <= addr + 17'd1;
      end
    end
  end

endmodule
